// File: rtl/fll_trunc_ctrl_if.sv
// Sample/control bus for fll_trunc_ctrl.
// master: source of FLL samples and window restart; sink of truncated samples and index.
// slave : the truncation controller.
//   in_valid     - in carries a valid discriminator sample
//   in[18:0]     - two's-complement FLL sample
//   clear        - synchronous window restart (index retained)
//   index[4:0]   - current truncation index (14..17)
//   index_update - one-cycle pulse at each window close
//   out[14:0]    - truncated sample {in[18], in[index:index-13]}
//   out_valid    - out holds a new truncated sample
interface fll_trunc_ctrl_if;
  logic        in_valid;
  logic [18:0] in;
  logic        clear;
  logic [4:0]  index;
  logic        index_update;
  logic [14:0] out;
  logic        out_valid;

  modport master (
    output in_valid, in, clear,
    input  index, index_update, out, out_valid
  );

  modport slave (
    input  in_valid, in, clear,
    output index, index_update, out, out_valid
  );
endinterface

// File: rtl/fll_trunc_ctrl.sv
// Adaptive truncation of a 19-bit FLL discriminator sample to 15 bits.
// The peak magnitude over each WINDOW_LEN-sample window selects the MSB
// position (index 14..17) kept for the following samples; the index rises
// immediately on demand and steps down by one only after HOLD_WINDOWS
// consecutive low-demand windows.
// Ports:
//   clk     - clock, all state updates on rising edge
//   reset_n - synchronous active-low reset
//   bus     - fll_trunc_ctrl_if.slave (sample in, truncated sample/index out)
module fll_trunc_ctrl #(
  parameter int unsigned WINDOW_LEN   = 16,
  parameter int unsigned HOLD_WINDOWS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  fll_trunc_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W  = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);
  localparam int unsigned IN_W   = 19;
  localparam int unsigned OUT_W  = 15;
  localparam int unsigned IDX_W  = 5;

  localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(14);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IN_W-1:0]    r_peak, w_peak_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [IDX_W-1:0]   r_index, w_index_nxt;
  logic               r_index_update, w_index_update_nxt;
  logic [OUT_W-1:0]   r_out, w_out_nxt;
  logic               r_out_valid;

  logic [IN_W-1:0]    w_mag;
  logic [IN_W-1:0]    w_peak_new;
  logic [IDX_W-1:0]   w_req;
  logic [13:0]        w_field;
  logic               w_close;
  logic [HOLD_W-1:0]  w_hold_inc;

  // Saturating magnitude: the most negative code maps to the largest positive.
  always_comb begin
    if (bus.in == 19'h40000)
      w_mag = 19'h3FFFF;
    else if (bus.in[18])
      w_mag = ~bus.in + 19'd1;
    else
      w_mag = bus.in;
  end

  assign w_peak_new = (w_mag > r_peak) ? w_mag : r_peak;

  // Required index from the peak including the current (closing) sample.
  always_comb begin
    if (w_peak_new[18:17] != 2'b00)
      w_req = IDX_W'(17);
    else if (w_peak_new[16])
      w_req = IDX_W'(16);
    else if (w_peak_new[15])
      w_req = IDX_W'(15);
    else
      w_req = IDX_W'(14);
  end

  // Keep 14 magnitude bits below the selected MSB position, with the sign on top.
  always_comb begin
    case (r_index)
      5'd15:   w_field = bus.in[15:2];
      5'd16:   w_field = bus.in[16:3];
      5'd17:   w_field = bus.in[17:4];
      default: w_field = bus.in[14:1];
    endcase
  end

  assign w_close    = (r_cnt == CNT_W'(WINDOW_LEN - 1));
  assign w_hold_inc = r_hold + HOLD_W'(1);

  // Next-state and window/index decision logic.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_peak_nxt         = r_peak;
    w_hold_nxt         = r_hold;
    w_index_nxt        = r_index;
    w_index_update_nxt = 1'b0;
    w_out_nxt          = r_out;

    // Truncation uses the index held this cycle, regardless of clear.
    if (bus.in_valid)
      w_out_nxt = {bus.in[18], w_field};

    if (bus.clear) begin
      // Clear wins over window accounting and suppresses any close.
      w_cnt_nxt   = '0;
      w_peak_nxt  = '0;
      w_hold_nxt  = '0;
      w_state_nxt = ST_FILL;
    end else if (bus.in_valid) begin
      if (w_close) begin
        w_cnt_nxt          = '0;
        w_peak_nxt         = '0;
        w_index_update_nxt = 1'b1;
        case (r_state)
          ST_FILL: w_state_nxt = ST_RUN;
          default: w_state_nxt = ST_RUN;
        endcase
        if (w_req > r_index) begin
          w_index_nxt = w_req;
          w_hold_nxt  = '0;
        end else if (w_req < r_index) begin
          if (w_hold_inc >= HOLD_W'(HOLD_WINDOWS)) begin
            w_index_nxt = (r_index > IDX_MIN) ? (r_index - IDX_W'(1)) : IDX_MIN;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt  = w_hold_inc;
          end
        end else begin
          w_hold_nxt = '0;
        end
      end else begin
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        w_peak_nxt = w_peak_new;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_FILL;
      r_cnt          <= '0;
      r_peak         <= '0;
      r_hold         <= '0;
      r_index        <= IDX_MIN;
      r_index_update <= 1'b0;
      r_out          <= '0;
      r_out_valid    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_peak         <= w_peak_nxt;
      r_hold         <= w_hold_nxt;
      r_index        <= w_index_nxt;
      r_index_update <= w_index_update_nxt;
      r_out          <= w_out_nxt;
      r_out_valid    <= bus.in_valid;
    end
  end

  assign bus.index        = r_index;
  assign bus.index_update = r_index_update;
  assign bus.out          = r_out;
  assign bus.out_valid    = r_out_valid;

endmodule

// File: tb/tb_fll_trunc_ctrl.sv
// Directed self-checking bench for fll_trunc_ctrl (WINDOW_LEN=4, HOLD_WINDOWS=2).
module tb_fll_trunc_ctrl;

  logic clk;
  logic reset_n;

  int n_checks;
  int n_fail;

  fll_trunc_ctrl_if u_if ();

  fll_trunc_ctrl #(
    .WINDOW_LEN   (4),
    .HOLD_WINDOWS (2)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, then check outputs produced at that edge.
  task automatic send(input string tag, input logic v, input logic [18:0] d, input logic c,
                      input logic exp_ov, input logic [14:0] exp_out,
                      input logic exp_upd, input logic [4:0] exp_idx);
    u_if.in_valid = v;
    u_if.in       = d;
    u_if.clear    = c;
    @(posedge clk);
    #1;
    check_eq({tag, ".out_valid"},    32'(u_if.out_valid),    32'(exp_ov));
    check_eq({tag, ".out"},          32'(u_if.out),          32'(exp_out));
    check_eq({tag, ".index_update"}, 32'(u_if.index_update), 32'(exp_upd));
    check_eq({tag, ".index"},        32'(u_if.index),        32'(exp_idx));
  endtask

  task automatic smp(input string tag, input logic [18:0] d, input logic [14:0] exp_out,
                     input logic exp_upd, input logic [4:0] exp_idx);
    send(tag, 1'b1, d, 1'b0, 1'b1, exp_out, exp_upd, exp_idx);
  endtask

  task automatic do_reset(input string tag);
    reset_n       = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in       = 19'd100;
    u_if.clear    = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, ".index"},        32'(u_if.index),        32'd14);
    check_eq({tag, ".out"},          32'(u_if.out),          32'd0);
    check_eq({tag, ".out_valid"},    32'(u_if.out_valid),    32'd0);
    check_eq({tag, ".index_update"}, 32'(u_if.index_update), 32'd0);
    reset_n       = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.clear    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in       = '0;
    u_if.clear    = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // 4 x +1000 at index 14: out keeps in[14:1] = 500.
    for (int i = 0; i < 4; i++)
      smp($sformatf("w1s%0d", i), 19'd1000, 15'h01F4, (i == 3), 5'd14);
    send("w1idle", 1'b0, 19'd0, 1'b0, 1'b0, 15'h01F4, 1'b0, 5'd14);

    // One +40000 sample -> index 15 after close; window still truncated at 14.
    smp("w2s0", 19'd100,   15'h0032, 1'b0, 5'd14);
    smp("w2s1", 19'd40000, 15'h0E20, 1'b0, 5'd14);
    smp("w2s2", 19'd100,   15'h0032, 1'b0, 5'd14);
    smp("w2s3", 19'd100,   15'h0032, 1'b1, 5'd15);

    // Saturating -262144 -> index 17.
    for (int i = 0; i < 3; i++)
      smp($sformatf("w3s%0d", i), 19'd100, 15'h0019, 1'b0, 5'd15);
    smp("w3s3", 19'h40000, 15'h4000, 1'b1, 5'd17);

    // Step-down with hold of 2 windows: 17, 16, 16, 15.
    for (int i = 0; i < 4; i++)
      smp($sformatf("w4as%0d", i), 19'd100, 15'h0006, (i == 3), 5'd17);
    smp("w4bs0", 19'h7FC18, 15'h7FC1, 1'b0, 5'd17);
    for (int i = 1; i < 4; i++)
      smp($sformatf("w4bs%0d", i), 19'd100, 15'h0006, (i == 3), (i == 3) ? 5'd16 : 5'd17);
    for (int i = 0; i < 4; i++)
      smp($sformatf("w4cs%0d", i), 19'd100, 15'h000C, (i == 3), 5'd16);
    for (int i = 0; i < 4; i++)
      smp($sformatf("w4ds%0d", i), 19'd100, 15'h000C, (i == 3), (i == 3) ? 5'd15 : 5'd16);

    // Clear mid-window: sample on clear cycle still output, window restarts.
    smp("w5s0", 19'd100, 15'h0019, 1'b0, 5'd15);
    smp("w5s1", 19'd100, 15'h0019, 1'b0, 5'd15);
    send("w5clr", 1'b1, 19'd100, 1'b1, 1'b1, 15'h0019, 1'b0, 5'd15);
    for (int i = 0; i < 4; i++)
      smp($sformatf("w5p%0d", i), 19'd100, 15'h0019, (i == 3), 5'd15);

    // Clear on the closing sample suppresses the close and clears hold.
    for (int i = 0; i < 3; i++)
      smp($sformatf("w6s%0d", i), 19'd100, 15'h0019, 1'b0, 5'd15);
    send("w6clr", 1'b1, 19'd100, 1'b1, 1'b1, 15'h0019, 1'b0, 5'd15);
    for (int i = 0; i < 4; i++)
      smp($sformatf("w7s%0d", i), 19'd100, 15'h0019, (i == 3), 5'd15);

    // Reach index 16, reset mid-window, next close after 4 fresh samples.
    smp("w8s0", 19'd70000, 15'h045C, 1'b0, 5'd15);
    for (int i = 1; i < 4; i++)
      smp($sformatf("w8s%0d", i), 19'd100, 15'h0019, (i == 3), (i == 3) ? 5'd16 : 5'd15);
    smp("w9s0", 19'd100, 15'h000C, 1'b0, 5'd16);
    smp("w9s1", 19'd100, 15'h000C, 1'b0, 5'd16);
    do_reset("rst1");
    for (int i = 0; i < 4; i++)
      smp($sformatf("w10s%0d", i), 19'd100, 15'h0032, (i == 3), 5'd14);
    send("w10idle", 1'b0, 19'd0, 1'b0, 1'b0, 15'h0032, 1'b0, 5'd14);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
